// File: rtl/decoder_sched_pkg.sv
// Shared types and helpers for the 3:8 decoder round-robin scheduler.
// Build option: GUARD_CYCLE_EN inserts one idle (GUARD) cycle between grants.
package decoder_sched_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    // Scheduler states; GUARD is only reachable when GUARD_CYCLE_EN is defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Round-robin successor of a decoder line index, wrapping 7 -> 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/decoder3_8_rr_scheduler_rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, mod 8.
module rr_pick8
    import decoder_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned DBL_W = 2 * N_REQ;

    logic [DBL_W-1:0] dbl;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate so that the pointer position lands on bit 0.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
    end

    // Priority-encode the rotated vector; lowest set bit wins.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    // Un-rotate the offset back to an absolute line index.
    always_comb begin
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/decoder3_8_rr_scheduler.sv
// Round-robin scheduler driving a 3:8 decoder's en/A/B/C inputs.
// Holds each winner's select for a programmable dwell; early release when the
// owner drops its request. Define GUARD_CYCLE_EN for a one-cycle break between grants.
module decoder3_8_rr_scheduler
    import decoder_sched_pkg::*;
#(
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned N_REQ   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy
);

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   ptr_q, ptr_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               en_q, en_n;
    logic               busy_q, busy_n;

    logic               grant_end_c;
    logic [IDX_W-1:0]   arb_ptr_c;
    logic [DWELL_W-1:0] load_c;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;

    // A grant ends on counter expiry or when its owner stops requesting.
    assign grant_end_c = (state_q == GRANT) && ((cnt_q == '0) || !req[idx_q]);

    // While granting, arbitrate from the pointer the grant end would produce.
    assign arb_ptr_c = (state_q == GRANT) ? next_idx(idx_q) : ptr_q;

    // Dwell of zero behaves as one cycle.
    assign load_c = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    rr_pick8 u_pick (
        .req (req),
        .ptr (arb_ptr_c),
        .any (pick_any),
        .idx (pick_idx)
    );

    // State and output registers; reset drops en without needing a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            en_q    <= en_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        en_n    = en_q;
        busy_n  = busy_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    idx_n   = pick_idx;
                    cnt_n   = load_c;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end
            end

            GRANT: begin
                if (grant_end_c) begin
                    ptr_n = arb_ptr_c;
`ifdef GUARD_CYCLE_EN
                    state_n = GUARD;
                    en_n    = 1'b0;
                    busy_n  = 1'b1;
`else
                    if (pick_any) begin
                        state_n = GRANT;
                        idx_n   = pick_idx;
                        cnt_n   = load_c;
                        en_n    = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        en_n    = 1'b0;
                        busy_n  = 1'b0;
                    end
`endif
                end else begin
                    cnt_n = cnt_q - DWELL_W'(1);
                    en_n  = 1'b1;
                end
            end

`ifdef GUARD_CYCLE_EN
            GUARD: begin
                if (pick_any) begin
                    state_n = GRANT;
                    idx_n   = pick_idx;
                    cnt_n   = load_c;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end
            end
`endif

            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Decoder-facing outputs; select holds its last value while en is low.
    assign en        = en_q;
    assign gnt_valid = en_q;
    assign gnt_idx   = idx_q;
    assign A         = idx_q[2];
    assign B         = idx_q[1];
    assign C         = idx_q[0];
    assign busy      = busy_q;

endmodule

// File: tb/tb_decoder3_8_rr_scheduler.sv
// Self-checking bench for decoder3_8_rr_scheduler: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_decoder3_8_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [3:0] dwell;
    logic       en, A, B, C, gnt_valid, busy;
    logic [2:0] gnt_idx;

    int n_cmp;
    int n_bad;

    // Behavioural model: grant ownership, remaining cycles, pointer.
    bit m_active;
    bit m_guard;
    int m_idx;
    int m_rem;
    int m_ptr;

    decoder3_8_rr_scheduler #(.DWELL_W(4), .N_REQ(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .dwell     (dwell),
        .en        (en),
        .A         (A),
        .B         (B),
        .C         (C),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_guard  = 1'b0;
        m_idx    = 0;
        m_rem    = 0;
        m_ptr    = 0;
    endtask

    // Start a new grant: scan ptr, ptr+1, ... for the first requester.
    task automatic model_start(input logic [7:0] r, input logic [3:0] d);
        for (int k = 0; k < 8; k++) begin
            if (r[(m_ptr + k) % 8]) begin
                m_idx    = (m_ptr + k) % 8;
                m_rem    = (d == 0) ? 1 : int'(d);
                m_active = 1'b1;
                return;
            end
        end
    endtask

    // One clock edge of the scheduler's rules, given the sampled inputs.
    task automatic model_step(input logic [7:0] r, input logic [3:0] d);
        if (!m_active) begin
            m_guard = 1'b0;
            if (r != 0) model_start(r, d);
        end else begin
            m_rem--;
            if (m_rem == 0 || !r[m_idx]) begin
                m_ptr    = (m_idx + 1) % 8;
                m_active = 1'b0;
`ifdef GUARD_CYCLE_EN
                m_guard = 1'b1;
`else
                if (r != 0) model_start(r, d);
`endif
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".en"},        32'(en),        32'(m_active));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_active));
        check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(m_idx));
        check({tag, ".abc"},       32'({A, B, C}), 32'(m_idx));
        check({tag, ".busy"},      32'(busy),      32'(m_active | m_guard));
    endtask

    // Advance one edge, update the model with the inputs seen at that edge, compare.
    task automatic step(input string tag);
        logic [7:0] r;
        logic [3:0] d;
        r = req;
        d = dwell;
        @(posedge clk);
        model_step(r, d);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("rst_async");
        repeat (3) @(posedge clk);
        #1;
        compare_all("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        req   = '0;
        dwell = 4'd3;
        rst_n = 1'b1;
        model_reset();
        #2;

        // Reset values, then idle with no requests.
        do_reset();
        check("rst_en_const", 32'(en), 32'd0);
        check("rst_busy_const", 32'(busy), 32'd0);
        repeat (3) step("idle");

        // Single requester 5: one-cycle latency, re-grant back-to-back.
        req = 8'h20;
        step("solo5");
        check("solo5_first_idx", 32'(gnt_idx), 32'd5);
        check("solo5_first_en", 32'(en), 32'd1);
        repeat (8) step("solo5");
        req = 8'h00;
        repeat (5) step("solo5_drain");

        // Three requesters held from reset: order 0,2,7,0.
        do_reset();
        req = 8'b1000_0101;
`ifndef GUARD_CYCLE_EN
        begin
            int order [4] = '{0, 2, 7, 0};
            for (int i = 0; i < 12; i++) begin
                step("rr3");
                check("rr3_order", 32'(gnt_idx), 32'(order[i / 3]));
                check("rr3_en_never_drops", 32'(en), 32'd1);
            end
        end
`else
        repeat (16) step("rr3");
`endif
        req = 8'h00;
        repeat (4) step("rr3_drain");

        // Early release: owner drops after one granted cycle; pointer moves to 3.
        do_reset();
        req = 8'h04;
        step("early");
        check("early_idx", 32'(gnt_idx), 32'd2);
        req = 8'h00;
        step("early_rel");
        check("early_en_low", 32'(en), 32'd0);
        req = 8'h09;
        step("early_ptr");
        step("early_ptr");
        req = 8'h00;
        repeat (5) step("early_drain");

        // Asynchronous reset mid-grant, then arbitration restarts from 0.
        do_reset();
        req   = 8'h10;
        dwell = 4'd5;
        step("midrst");
        step("midrst");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_en_async", 32'(en), 32'd0);
        compare_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h81;
        dwell = 4'd3;
        step("midrst_rearb");
        check("midrst_rearb_idx", 32'(gnt_idx), 32'd0);
        repeat (6) step("midrst_rearb");

`ifdef GUARD_CYCLE_EN
        // Break-before-make with two requesters.
        do_reset();
        req = 8'h03;
        repeat (16) step("guard");
`endif

        // Randomized traffic with occasional dwell extremes and async resets.
        req   = 8'h00;
        dwell = 4'd3;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step("rand");
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'h00;
                    1: req = 8'(1 << $urandom_range(0, 7));
                    default: req = 8'($urandom & $urandom);
                endcase
            end
            case ($urandom_range(0, 5))
                0: dwell = 4'd0;
                1: dwell = 4'd15;
                default: dwell = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
